// File: rtl/cache_mem_arbiter_if.sv
// Bundles the I-cache, D-cache and RAM signals of the cache/memory arbiter.
// The arbiter uses the master view; the caches and RAM model use the slave view.
interface cache_mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one RAM port between I-cache and D-cache; D wins unless I has starved STARVE_MAX D grants.
// Latency: grant registered one cycle after request, completion on the first RAM ACCESS cycle (min 2 cycles).
// Backpressure: requesters stall on iwait/dwait; RAM BUSY/FREE/ERROR holds the grant and re-drives the RAM.
module cache_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.master  bus
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            err_q, err_d;
    logic            d_req;
    logic            ram_done;

    assign d_req    = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == RAM_ACCESS);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        err_d    = err_q | (bus.ramstate == RAM_ERROR);
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d = (bus.iREN && starve_q == STARVE_LIM) ? IGRANT : DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                // A withdrawn request abandons the grant without touching the starve count.
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end
            end
            DGRANT: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    state_d = IDLE;
                    if (!bus.iREN) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // RAM side follows the live inputs of the granted requester so ERROR cycles retry the same access.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state_q)
            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            default: ;
        endcase
    end

    assign bus.iwait = bus.iREN & ~((state_q == IGRANT) & ram_done);
    assign bus.dwait = d_req    & ~((state_q == DGRANT) & ram_done);
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change 1 time unit after a rising edge,
// outputs are checked 2 units after that, well away from both clock edges.
module tb_cache_mem_arbiter;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        nRST          = 1'b0;
        bus.iREN      = 1'b0;
        bus.iaddr     = '0;
        bus.dREN      = 1'b0;
        bus.dWEN      = 1'b0;
        bus.daddr     = '0;
        bus.dstore    = '0;
        bus.ramload   = '0;
        bus.ramstate  = FREE;
        #2;
        chk("rst_ramREN",  {31'd0, bus.ramREN}, 32'd0);
        chk("rst_ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_err",     {31'd0, bus.err}, 32'd0);
        chk("rst_iwait",   {31'd0, bus.iwait}, 32'd0);
        tick();
        tick();
        nRST = 1'b1;

        // I read alone: grant next cycle, ACCESS on the second cycle.
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        settle();
        chk("i_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("i_idle_iwait",  {31'd0, bus.iwait}, 32'd1);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        settle();
        chk("i_grant_ramREN",  {31'd0, bus.ramREN}, 32'd1);
        chk("i_grant_ramaddr", bus.ramaddr, 32'h40);
        chk("i_done_iwait",    {31'd0, bus.iwait}, 32'd0);
        chk("i_done_iload",    bus.iload, 32'hDEADBEEF);
        tick();
        bus.ramstate = FREE;
        settle();
        chk("i_back_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("i_back_idle_iwait",  {31'd0, bus.iwait}, 32'd1);
        bus.iREN = 1'b0;
        tick();
        settle();
        chk("i_quiet_ramREN", {31'd0, bus.ramREN}, 32'd0);

        // I read and D write together: D first, then I.
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        bus.ramstate = BUSY;
        tick();
        settle();
        chk("dw_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
        chk("dw_ramREN",   {31'd0, bus.ramREN}, 32'd0);
        chk("dw_ramaddr",  bus.ramaddr, 32'h80);
        chk("dw_ramstore", bus.ramstore, 32'h1234);
        chk("dw_busy_iwait", {31'd0, bus.iwait}, 32'd1);
        chk("dw_busy_dwait", {31'd0, bus.dwait}, 32'd1);
        tick();
        bus.ramstate = ACCESS;
        settle();
        chk("dw_done_dwait", {31'd0, bus.dwait}, 32'd0);
        chk("dw_done_iwait", {31'd0, bus.iwait}, 32'd1);
        tick();
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        settle();
        chk("dw_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        chk("dw_idle_iwait",  {31'd0, bus.iwait}, 32'd1);
        tick();
        settle();
        chk("i2_ramREN",  {31'd0, bus.ramREN}, 32'd1);
        chk("i2_ramaddr", bus.ramaddr, 32'h44);
        chk("i2_ramstore", bus.ramstore, 32'h0);
        bus.ramstate = ACCESS;
        settle();
        chk("i2_done_iwait", {31'd0, bus.iwait}, 32'd0);
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;

        // Starvation: four D completions with I pending, then I must win.
        bus.iREN = 1'b1; bus.iaddr = 32'h48;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            bus.ramstate = FREE;
            settle();
            chk("st_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
            tick();
            settle();
            chk("st_d_ramaddr", bus.ramaddr, 32'h100);
            bus.ramstate = ACCESS;
            settle();
            chk("st_d_dwait", {31'd0, bus.dwait}, 32'd0);
            chk("st_d_iwait", {31'd0, bus.iwait}, 32'd1);
            tick();
        end
        bus.ramstate = FREE;
        tick();
        settle();
        chk("st_5th_is_i_ramaddr", bus.ramaddr, 32'h48);
        bus.ramstate = ACCESS;
        settle();
        chk("st_i_iwait", {31'd0, bus.iwait}, 32'd0);
        chk("st_i_dwait", {31'd0, bus.dwait}, 32'd1);
        tick();
        bus.ramstate = FREE;
        tick();
        settle();
        chk("st_cleared_d_first", bus.ramaddr, 32'h100);
        bus.iREN = 1'b0; bus.ramstate = ACCESS;
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        tick();

        // ERROR retry on a D read, then ACCESS.
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        tick();
        bus.ramstate = ERROR;
        settle();
        chk("er1_ramREN",  {31'd0, bus.ramREN}, 32'd1);
        chk("er1_ramaddr", bus.ramaddr, 32'h200);
        chk("er1_dwait",   {31'd0, bus.dwait}, 32'd1);
        tick();
        settle();
        chk("er2_ramREN",  {31'd0, bus.ramREN}, 32'd1);
        chk("er2_ramaddr", bus.ramaddr, 32'h200);
        chk("er2_err",     {31'd0, bus.err}, 32'd1);
        tick();
        bus.ramstate = ACCESS;
        settle();
        chk("er_acc_ramaddr", bus.ramaddr, 32'h200);
        chk("er_acc_dwait",   {31'd0, bus.dwait}, 32'd0);
        chk("er_acc_err",     {31'd0, bus.err}, 32'd1);
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        tick();
        settle();
        chk("er_sticky", {31'd0, bus.err}, 32'd1);

        // Asynchronous reset in the middle of a D write grant.
        bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h55; bus.ramstate = BUSY;
        tick();
        settle();
        chk("rs_grant_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rs_async_ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
        chk("rs_async_ramREN",  {31'd0, bus.ramREN}, 32'd0);
        chk("rs_async_ramaddr", bus.ramaddr, 32'h0);
        chk("rs_async_err",     {31'd0, bus.err}, 32'd0);
        tick();
        nRST = 1'b1;
        settle();
        chk("rs_release_idle", {31'd0, bus.ramWEN}, 32'd0);
        tick();
        settle();
        chk("rs_rearb_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        bus.ramstate = ACCESS;
        tick();
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        tick();

        // D read withdrawn before ACCESS.
        bus.dREN = 1'b1; bus.daddr = 32'h400;
        tick();
        bus.ramstate = BUSY;
        settle();
        chk("dr_grant_ramREN", {31'd0, bus.ramREN}, 32'd1);
        tick();
        bus.dREN = 1'b0;
        settle();
        chk("dr_drop_dwait",  {31'd0, bus.dwait}, 32'd0);
        chk("dr_drop_ramREN", {31'd0, bus.ramREN}, 32'd0);
        tick();
        settle();
        chk("dr_idle_ramaddr", bus.ramaddr, 32'h0);
        bus.ramstate = FREE;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
